pma_attr_lookup: RTL and testbench
==================================

Name: pma_attr_lookup

Overview:
- Pipelined physical-memory-attribute (PMA) lookup stage between the MMU/PMP translation output and the LSU/frontend memory request path.
- Per physical address, resolves non-idempotent, executable and cacheable attributes from the region rules in the core configuration.
- Flags fetches to non-executable space.
- Replaces per-consumer combinational region scans with one registered, back-pressurable 2-stage unit, so the 16-rule compare tree is off the critical path.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty: core configuration; supplies rule counts, bases and lengths (NrMaxRules = 16 slots).
- TagWidth, 4: width of the opaque request tag carried through the pipeline.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  drop all in-flight lookups
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  64  physical address (upper bits zero when PLEN<64)
- req_fetch_i  in  1  1 = instruction fetch, 0 = data access
- req_tag_i  in  TagWidth  opaque tag
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer ready
- rsp_tag_o  out  TagWidth  tag of the request
- rsp_nonidem_o  out  1  address is in a non-idempotent region
- rsp_nonidem_idx_o  out  4  lowest matching non-idempotent rule index (0 if none)
- rsp_exec_o  out  1  address is executable
- rsp_cache_o  out  1  address is cacheable
- rsp_fetch_fault_o  out  1  req_fetch & !rsp_exec

Behaviour:
- Stage 1 (S1) on accept:
  - registers tag and fetch flag;
  - registers three 16-bit match vectors (nonidem, exec, cache);
  - rule k matches iff k < NrXxxRules and base <= addr and {1'b0,addr} < 65-bit (base + len), so there is no wrap at the top of the address space;
  - rule slots at or above the configured count force 0.
- Stage 2 (S2):
  - registers OR-reductions of each vector and the priority-encoded lowest set index of the nonidem vector;
  - if NrExecuteRegionRules == 0, exec = 1 regardless of address;
  - fetch_fault = fetch & !exec;
  - outputs drive directly from S2 registers.
- Latency: accept in cycle N -> rsp_valid_o in cycle N+2 when not stalled. Throughput is 1 per cycle.
- Handshake:
  - s2_en = !s2_valid | rsp_ready_i;
  - s1_en = !s1_valid | s2_en;
  - req_ready_o = s1_en (combinational from rsp_ready_i; no combinational path from req_valid_i).
  - On s2_en, S2 loads S1 contents and valid.
  - rsp_valid_o and all rsp_* stay stable while rsp_valid_o & !rsp_ready_i.
  - Responses are in strict request order.
- Capacity: 2 outstanding requests. With rsp_ready_i held low, the 3rd request sees req_ready_o = 0.
- flush_i:
  - next cycle s1_valid = s2_valid = 0;
  - a request presented in the flush cycle is not accepted (req_ready_o forced 0 while flush_i = 1);
  - a response handshaking in the flush cycle completes normally.
- Reset:
  - rst_i sampled high clears s1_valid and s2_valid;
  - all rsp_* data registers reset to 0, so rsp_valid_o = 0 and req_ready_o = 1 the cycle after reset deasserts;
  - reset mid-operation discards in-flight lookups with no response.
- Data registers (non-valid) update only on the stage enable, with no spurious toggling during stall.
- Elaboration:
  - assertion failure if any rule count > 16;
  - check_cfg(CVA6Cfg) is called.

Test Plan:
- Cached rule 0 base 0x8000_0000 len 0x4000_0000:
  - addr 0xBFFF_FFFF -> rsp_cache_o = 1;
  - addr 0xC000_0000 -> rsp_cache_o = 0;
  - addr 0x7FFF_FFFF -> 0;
  - each response arrives exactly 2 cycles after accept.
- Overflow: nonidem rules 0 base 0xFFFF_FFFF_FFFF_F000 len 0x2000 and 3 base 0x1000_0000 len 0x1000:
  - addr 0xFFFF_FFFF_FFFF_FFF8 -> nonidem = 1, idx = 0;
  - addr 0x1000_0800 -> nonidem = 1, idx = 3;
  - addr 0x2000_0000 -> nonidem = 0, idx = 0.
- Exec rules = 0: fetch to 0x0 -> exec = 1, fault = 0. Exec rule 0 base 0x1_0000 len 0x1_0000: fetch 0x3_0000 -> exec = 0, fault = 1; data access to same addr -> fault = 0.
- Backpressure:
  - rsp_ready_i = 0, send tags 1, 2, 3 back to back -> 1 and 2 accepted, req_ready_o = 0 on 3, rsp_tag_o held at 1 and stable;
  - release rsp_ready_i -> tags 1, 2, 3 in order on consecutive cycles.
- Flush with 2 in flight plus a request held valid -> no responses for flushed tags, held request accepted the cycle after flush_i drops, its response 2 cycles later.
- Assert rst_i for 1 cycle with 2 in flight and rsp_ready_i = 0 -> rsp_valid_o = 0 and all rsp_* = 0 next cycle, req_ready_o = 1, no stale response ever emitted.

Source files
------------

// File: rtl/pma_attr_lookup.sv
// ============================================================================
// Module   : pma_attr_lookup (with config_pkg)
// Brief    : Two-stage registered PMA lookup: non-idempotent / exec / cache.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package config_pkg;
  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    logic [31:0]       NrNonIdempotentRules;
    logic [15:0][63:0] NonIdempotentAddrBase;
    logic [15:0][63:0] NonIdempotentLength;
    logic [31:0]       NrExecuteRegionRules;
    logic [15:0][63:0] ExecuteRegionAddrBase;
    logic [15:0][63:0] ExecuteRegionLength;
    logic [31:0]       NrCachedRegionRules;
    logic [15:0][63:0] CachedRegionAddrBase;
    logic [15:0][63:0] CachedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  function automatic bit check_cfg(input cva6_cfg_t cfg);
    return (cfg.NrNonIdempotentRules <= NrMaxRules) &&
           (cfg.NrExecuteRegionRules <= NrMaxRules) &&
           (cfg.NrCachedRegionRules  <= NrMaxRules);
  endfunction
endpackage

module pma_attr_lookup #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_empty,
  parameter int unsigned           TagWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [63:0]         req_addr_i,
  input  logic                req_fetch_i,
  input  logic [TagWidth-1:0] req_tag_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [TagWidth-1:0] rsp_tag_o,
  output logic                rsp_nonidem_o,
  output logic [3:0]          rsp_nonidem_idx_o,
  output logic                rsp_exec_o,
  output logic                rsp_cache_o,
  output logic                rsp_fetch_fault_o
);

  localparam int c_NR_NI = int'(CVA6Cfg.NrNonIdempotentRules);
  localparam int c_NR_EX = int'(CVA6Cfg.NrExecuteRegionRules);
  localparam int c_NR_CA = int'(CVA6Cfg.NrCachedRegionRules);

  if ((c_NR_NI > 16) || (c_NR_EX > 16) || (c_NR_CA > 16)) begin : g_rule_count_err
    $error("pma_attr_lookup: a rule count exceeds 16 slots");
  end
  if (!config_pkg::check_cfg(CVA6Cfg)) begin : g_cfg_err
    $error("pma_attr_lookup: check_cfg rejected the core configuration");
  end

  // End of region computed in 65 bits so a region touching 2^64 never wraps.
  function automatic logic in_rule(input logic [63:0] addr, input logic [63:0] base,
                                   input logic [63:0] len);
    return (addr >= base) && ({1'b0, addr} < ({1'b0, base} + {1'b0, len}));
  endfunction

  logic [15:0] w_ni_match, w_ex_match, w_ca_match;

  for (genvar k = 0; k < 16; k++) begin : g_rule
    if (k < c_NR_NI) begin : g_ni_on
      assign w_ni_match[k] = in_rule(req_addr_i, CVA6Cfg.NonIdempotentAddrBase[k],
                                     CVA6Cfg.NonIdempotentLength[k]);
    end else begin : g_ni_off
      assign w_ni_match[k] = 1'b0;
    end
    if (k < c_NR_EX) begin : g_ex_on
      assign w_ex_match[k] = in_rule(req_addr_i, CVA6Cfg.ExecuteRegionAddrBase[k],
                                     CVA6Cfg.ExecuteRegionLength[k]);
    end else begin : g_ex_off
      assign w_ex_match[k] = 1'b0;
    end
    if (k < c_NR_CA) begin : g_ca_on
      assign w_ca_match[k] = in_rule(req_addr_i, CVA6Cfg.CachedRegionAddrBase[k],
                                     CVA6Cfg.CachedRegionLength[k]);
    end else begin : g_ca_off
      assign w_ca_match[k] = 1'b0;
    end
  end

  logic                r_s1_valid, r_s2_valid;
  logic [TagWidth-1:0] r_s1_tag;
  logic                r_s1_fetch;
  logic [15:0]         r_s1_ni, r_s1_ex, r_s1_ca;
  logic                w_s1_en, w_s2_en, w_accept;

  assign w_s2_en     = !r_s2_valid || rsp_ready_i;
  assign w_s1_en     = !r_s1_valid || w_s2_en;
  assign req_ready_o = w_s1_en && !flush_i;
  assign w_accept    = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= w_accept;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_tag   <= '0;
      r_s1_fetch <= 1'b0;
      r_s1_ni    <= '0;
      r_s1_ex    <= '0;
      r_s1_ca    <= '0;
    end else if (w_accept) begin
      r_s1_tag   <= req_tag_i;
      r_s1_fetch <= req_fetch_i;
      r_s1_ni    <= w_ni_match;
      r_s1_ex    <= w_ex_match;
      r_s1_ca    <= w_ca_match;
    end
  end

  logic [3:0] w_ni_idx;
  logic       w_exec;

  always_comb begin
    w_ni_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (r_s1_ni[i]) w_ni_idx = 4'(i);
    end
  end

  // With no execute rules configured the whole space is executable.
  if (c_NR_EX == 0) begin : g_exec_all
    assign w_exec = 1'b1;
  end else begin : g_exec_rules
    assign w_exec = |r_s1_ex;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_s2_valid <= 1'b0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_tag_o         <= '0;
      rsp_nonidem_o     <= 1'b0;
      rsp_nonidem_idx_o <= '0;
      rsp_exec_o        <= 1'b0;
      rsp_cache_o       <= 1'b0;
      rsp_fetch_fault_o <= 1'b0;
    end else if (w_s2_en && r_s1_valid) begin
      rsp_tag_o         <= r_s1_tag;
      rsp_nonidem_o     <= |r_s1_ni;
      rsp_nonidem_idx_o <= w_ni_idx;
      rsp_exec_o        <= w_exec;
      rsp_cache_o       <= |r_s1_ca;
      rsp_fetch_fault_o <= r_s1_fetch && !w_exec;
    end
  end

  assign rsp_valid_o = r_s2_valid;

endmodule

`default_nettype wire

// File: tb/tb_pma_attr_lookup.sv
// ============================================================================
// Module   : tb_pma_attr_lookup
// Brief    : Directed + random bench for pma_attr_lookup against a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pma_attr_lookup;

  typedef struct packed {
    logic       nonidem;
    logic [3:0] idx;
    logic       exec;
    logic       cache;
    logic       fault;
  } attr_t;

  typedef struct {
    logic [3:0] tag;
    int         acc;
    attr_t      a;
    attr_t      b;
  } entry_t;

  function automatic config_pkg::cva6_cfg_t mk_cfg(input bit with_exec);
    config_pkg::cva6_cfg_t c;
    c = '0;
    c.NrNonIdempotentRules     = 32'd4;
    c.NonIdempotentAddrBase[0] = 64'hFFFF_FFFF_FFFF_F000;
    c.NonIdempotentLength[0]   = 64'h2000;
    c.NonIdempotentAddrBase[1] = 64'h1000_0F00;
    c.NonIdempotentLength[1]   = 64'h200;
    c.NonIdempotentAddrBase[3] = 64'h1000_0000;
    c.NonIdempotentLength[3]   = 64'h1000;
    c.NonIdempotentAddrBase[5] = 64'h5000_0000;
    c.NonIdempotentLength[5]   = 64'h1000;
    c.NrExecuteRegionRules     = with_exec ? 32'd1 : 32'd0;
    c.ExecuteRegionAddrBase[0] = 64'h1_0000;
    c.ExecuteRegionLength[0]   = 64'h1_0000;
    c.ExecuteRegionAddrBase[1] = 64'h3_0000;
    c.ExecuteRegionLength[1]   = 64'h1000;
    c.NrCachedRegionRules      = 32'd1;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000;
    c.CachedRegionLength[0]    = 64'h4000_0000;
    c.CachedRegionAddrBase[1]  = 64'h0;
    c.CachedRegionLength[1]    = 64'h1000_0000;
    return c;
  endfunction

  localparam config_pkg::cva6_cfg_t c_CFG_A = mk_cfg(1'b1);
  localparam config_pkg::cva6_cfg_t c_CFG_B = mk_cfg(1'b0);

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_fetch, rsp_ready;
  logic [63:0] req_addr;
  logic [3:0]  req_tag;
  logic        req_ready, rsp_valid, rsp_nonidem, rsp_exec, rsp_cache, rsp_fault;
  logic [3:0]  rsp_tag, rsp_idx;
  logic        b_req_ready, b_rsp_valid, b_rsp_nonidem, b_rsp_exec, b_rsp_cache, b_rsp_fault;
  logic [3:0]  b_rsp_tag, b_rsp_idx;

  always #5 clk = ~clk;

  pma_attr_lookup #(.CVA6Cfg(c_CFG_A), .TagWidth(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_fetch_i(req_fetch), .req_tag_i(req_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_tag_o(rsp_tag),
    .rsp_nonidem_o(rsp_nonidem), .rsp_nonidem_idx_o(rsp_idx), .rsp_exec_o(rsp_exec),
    .rsp_cache_o(rsp_cache), .rsp_fetch_fault_o(rsp_fault)
  );

  pma_attr_lookup #(.CVA6Cfg(c_CFG_B), .TagWidth(4)) u_dut_noexec (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(b_req_ready), .req_addr_i(req_addr),
    .req_fetch_i(req_fetch), .req_tag_i(req_tag),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(rsp_ready), .rsp_tag_o(b_rsp_tag),
    .rsp_nonidem_o(b_rsp_nonidem), .rsp_nonidem_idx_o(b_rsp_idx), .rsp_exec_o(b_rsp_exec),
    .rsp_cache_o(b_rsp_cache), .rsp_fetch_fault_o(b_rsp_fault)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  int     now      = 0;
  entry_t q[$];

  function automatic bit in_region(input logic [63:0] a, input logic [63:0] base,
                                   input logic [63:0] len);
    return (a >= base) && ((a - base) < len);
  endfunction

  // Reference: walk the active rules of each kind, first non-idempotent hit wins.
  function automatic attr_t model(input config_pkg::cva6_cfg_t c, input logic [63:0] a,
                                  input logic f);
    attr_t r;
    r = '0;
    for (int k = 0; k < int'(c.NrNonIdempotentRules); k++) begin
      if (in_region(a, c.NonIdempotentAddrBase[k], c.NonIdempotentLength[k]) && !r.nonidem) begin
        r.nonidem = 1'b1;
        r.idx     = 4'(k);
      end
    end
    r.exec = (c.NrExecuteRegionRules == 0);
    for (int k = 0; k < int'(c.NrExecuteRegionRules); k++)
      if (in_region(a, c.ExecuteRegionAddrBase[k], c.ExecuteRegionLength[k])) r.exec = 1'b1;
    for (int k = 0; k < int'(c.NrCachedRegionRules); k++)
      if (in_region(a, c.CachedRegionAddrBase[k], c.CachedRegionLength[k])) r.cache = 1'b1;
    r.fault = f && !r.exec;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  // One clock: check outputs at negedge, then advance the model at posedge.
  task automatic step();
    bit     ev, er, hs, acc;
    entry_t e;
    @(negedge clk);
    ev = (q.size() != 0) && (now >= q[0].acc + 2);
    er = !flush && ((q.size() < 2) || rsp_ready);
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("rsp_valid_b", 64'(b_rsp_valid), 64'(ev));
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("req_ready_b", 64'(b_req_ready), 64'(er));
    if (ev) begin
      chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
      chk("rsp_attr", 64'({rsp_nonidem, rsp_idx, rsp_exec, rsp_cache, rsp_fault}), 64'(q[0].a));
      chk("rsp_tag_b", 64'(b_rsp_tag), 64'(q[0].tag));
      chk("rsp_attr_b", 64'({b_rsp_nonidem, b_rsp_idx, b_rsp_exec, b_rsp_cache, b_rsp_fault}),
          64'(q[0].b));
    end
    hs  = ev && rsp_ready;
    acc = req_valid && er;
    e.tag = req_tag;
    e.acc = now;
    e.a   = model(c_CFG_A, req_addr, req_fetch);
    e.b   = model(c_CFG_B, req_addr, req_fetch);
    @(posedge clk);
    now++;
    if (rst) begin
      q.delete();
    end else begin
      if (hs) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic f, input logic [3:0] t);
    req_valid = 1'b1;
    req_addr  = a;
    req_fetch = f;
    req_tag   = t;
    step();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_data"}, 64'({rsp_tag, rsp_nonidem, rsp_idx, rsp_exec, rsp_cache, rsp_fault}), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_data_b"},
        64'({b_rsp_tag, b_rsp_nonidem, b_rsp_idx, b_rsp_exec, b_rsp_cache, b_rsp_fault}), 64'd0);
  endtask

  logic [63:0] pool [12] = '{
    64'hBFFF_FFFF, 64'hC000_0000, 64'h7FFF_FFFF, 64'h8000_0000,
    64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_EFFF, 64'h1000_0800, 64'h1000_0F80,
    64'h5000_0000, 64'h1_0000, 64'h2_0000, 64'h3_0000
  };

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_fetch = 1'b0;
    req_addr = '0; req_tag = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_cleared("reset");

    // Cached region edges, back to back
    send(64'hBFFF_FFFF, 1'b0, 4'd1);
    send(64'hC000_0000, 1'b0, 4'd2);
    send(64'h7FFF_FFFF, 1'b0, 4'd3);
    send(64'h0, 1'b0, 4'd4);
    idle(3);

    // Non-idempotent rules, top-of-space region and inactive slot
    send(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 4'd5);
    send(64'h1000_0800, 1'b0, 4'd6);
    send(64'h2000_0000, 1'b0, 4'd7);
    send(64'h1000_0F80, 1'b0, 4'd8);
    send(64'h5000_0000, 1'b0, 4'd9);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd10);
    send(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 4'd11);
    idle(3);

    // Execute rules and fetch faults
    send(64'h0, 1'b1, 4'd1);
    send(64'h3_0000, 1'b1, 4'd2);
    send(64'h3_0000, 1'b0, 4'd3);
    send(64'h1_8000, 1'b1, 4'd4);
    send(64'h2_0000, 1'b1, 4'd5);
    idle(3);

    // Backpressure: third request held off until the consumer drains
    rsp_ready = 1'b0;
    send(64'h8000_0000, 1'b0, 4'd1);
    send(64'h1000_0000, 1'b0, 4'd2);
    repeat (3) send(64'h1_0000, 1'b1, 4'd3);
    rsp_ready = 1'b1;
    send(64'h1_0000, 1'b1, 4'd3);
    idle(4);

    // Flush with two in flight and a request held valid
    rsp_ready = 1'b0;
    send(64'hBFFF_0000, 1'b0, 4'd1);
    send(64'hBFFF_1000, 1'b0, 4'd2);
    flush = 1'b1;
    send(64'h1000_0F00, 1'b0, 4'd7);
    flush = 1'b0;
    rsp_ready = 1'b1;
    send(64'h1000_0F00, 1'b0, 4'd7);
    idle(4);

    // Flush while a response is handshaking
    send(64'h8000_0000, 1'b0, 4'd12);
    idle(1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(3);

    // Reset mid-operation
    rsp_ready = 1'b0;
    send(64'h8000_0000, 1'b0, 4'd1);
    send(64'h1000_0800, 1'b0, 4'd2);
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cleared("midreset");
    idle(2);
    rsp_ready = 1'b1;
    idle(3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      req_fetch = $urandom_range(0, 1) != 0;
      req_tag   = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_addr = {$urandom, $urandom};
      else req_addr = pool[$urandom_range(0, 11)] + 64'($urandom_range(0, 2)) - 64'd1;
      step();
    end
    flush = 1'b0;
    rsp_ready = 1'b1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
